// File: rtl/detect_count_bcd_display.sv
// Counts rising edges of the pattern detector's output in a 4-digit BCD counter
// and drives a multiplexed common-anode 7-segment display. DETECT_COUNT_LZ_BLANK_EN enables leading-zero blanking.
module detect_count_bcd_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int RD_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        detect,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [RD_W-1:0] RC_LAST = RD_W'(REFRESH_DIV - 1);

  logic            detect_d;
  logic            inc;
  logic [16:0]     inc_res;
  logic [RD_W-1:0] rc;
  logic            rc_tc;
  logic [1:0]      sel;
  logic [1:0]      sel_nxt;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;

  // Ripple BCD increment; returns {carry_out, next_value}. Codes >= 9 roll to 0.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] s);
    logic b;
    case (s)
      2'd3:    b = (v[15:12] == 4'd0);
      2'd2:    b = (v[15:8] == 8'd0);
      2'd1:    b = (v[15:4] == 12'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Stage p0: edge detect and BCD counter
  assign inc     = detect & ~detect_d;
  assign inc_res = bcd_inc(count_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect_d  <= 1'b0;
      count_bcd <= 16'h0000;
      wrap      <= 1'b0;
    end else begin
      detect_d <= detect;
      if (clr) begin
        count_bcd <= 16'h0000;
        wrap      <= 1'b0;
      end else if (inc) begin
        count_bcd <= inc_res[15:0];
        wrap      <= inc_res[16];
      end else begin
        wrap      <= 1'b0;
      end
    end
  end

  // Stage p1: refresh timebase and digit-select FSM; an/seg registered with sel
  assign rc_tc = (rc == RC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc  <= '0;
      sel <= 2'd0;
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      rc  <= rc_tc ? '0 : rc + RD_W'(1);
      sel <= sel_nxt;
      if (rc_tc) begin
        an  <= an_nxt;
        seg <= seg_nxt;
      end
    end
  end

  always_comb begin
    sel_nxt = sel;
    if (rc_tc) sel_nxt = sel + 2'd1;
  end

  always_comb begin
    an_nxt          = 4'b1111;
    an_nxt[sel_nxt] = 1'b0;
    seg_nxt         = seg_decode(count_bcd[sel_nxt*4 +: 4]);
`ifdef DETECT_COUNT_LZ_BLANK_EN
    if (lz_blank(count_bcd, sel_nxt)) seg_nxt = 7'b1111111;
`endif
  end

`ifndef DETECT_COUNT_LZ_BLANK_EN
  logic lz_unused;
  assign lz_unused = lz_blank(count_bcd, sel_nxt);
`endif

  assign dp = 1'b1;

endmodule
